dma_burst_planner: RTL and testbench

DMA_BURST_PLANNER -- requirements
Module: dma_burst_planner

---
 rtl/dma_burst_planner.sv | 220 ++++++++++++++++++++++
 tb/tb_dma_burst_planner.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_burst_planner.sv
// dma_burst_planner
//
// Splits a DMA job (start address + byte count) into a sequence of bursts.
// Each burst is limited by MAX_BEATS beats and is never allowed to cross a
// BOUNDARY-aligned address.
//
// For every burst the planner publishes:
//   * a beat-aligned address
//   * the length in beats minus one
//   * byte strobes for the first and the last beat
//   * a flag marking the final burst of the job
//
// Ports
//   clk, rstn           : clock, asynchronous active-low reset
//   start_i             : job request, sampled only while idle
//   addr_i, bytes_i     : job start address and job byte count
//   abort_i             : stop the job after the request currently offered
//   req_valid_o         : burst request valid
//   req_ready_i         : burst request ready
//   req_addr_o          : beat-aligned burst address
//   req_len_o           : burst length in beats minus one
//   req_first_strb_o    : byte strobes of the first beat
//   req_last_strb_o     : byte strobes of the last beat
//   req_last_o          : set on the final burst of the job
//   busy_o              : high whenever the planner is not idle
//   done_o              : one-cycle pulse when the job ends
//   aborted_o           : qualifies done_o, high if the job was aborted
module dma_burst_planner #(
    parameter int DATA_W    = 512,
    parameter int MAX_BEATS = 256,
    parameter int BOUNDARY  = 4096,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [LEN_W-1:0]      bytes_i,
    input  logic                  abort_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [ADDR_W-1:0]     req_addr_o,
    output logic [7:0]            req_len_o,
    output logic [DATA_W/8-1:0]   req_first_strb_o,
    output logic [DATA_W/8-1:0]   req_last_strb_o,
    output logic                  req_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  aborted_o
);

    localparam int BPB   = DATA_W / 8;
    localparam int OFF_W = $clog2(BPB);
    localparam int SPAN  = MAX_BEATS * BPB;

    // The working width must hold:
    //   * the remaining byte count
    //   * the distance to the next boundary
    //   * the maximum burst span
    // One extra bit is added so that sums such as off + n never wrap.
    localparam int W_B = $clog2(BOUNDARY) + 1;
    localparam int W_S = $clog2(SPAN) + 1;
    localparam int W_BS = (W_B > W_S) ? W_B : W_S;
    localparam int W_M = (LEN_W > W_BS) ? LEN_W : W_BS;
    localparam int CW = W_M + 1;

    typedef enum logic [1:0] {IDLE, CALC, ISSUE, FIN} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   a_reg;        // address of the next byte to move
    logic [CW-1:0]       r_reg;        // bytes still to move
    logic [CW-1:0]       n_reg;        // bytes covered by the offered burst
    logic                abort_reg;    // abort seen while a request was offered

    logic                valid_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [7:0]          len_reg;
    logic [BPB-1:0]      first_strb_reg;
    logic [BPB-1:0]      last_strb_reg;
    logic                last_reg;
    logic                done_reg;
    logic                aborted_reg;

    // Burst planning for the current address/remaining pair.
    logic [OFF_W-1:0]    off;
    logic [CW-1:0]       off_w;
    logic [CW-1:0]       to_bound;
    logic [CW-1:0]       to_span;
    logic [CW-1:0]       n_calc;
    logic [CW-1:0]       end_off;
    logic [CW-1:0]       beats;
    logic [7:0]          len_calc;
    logic [OFF_W-1:0]    last_off;
    logic [ADDR_W-1:0]   base_addr;
    logic [BPB-1:0]      first_strb;
    logic [BPB-1:0]      last_strb;

    always_comb begin
        off       = a_reg[OFF_W-1:0];
        off_w     = CW'(off);
        to_bound  = CW'(BOUNDARY) - CW'(a_reg & ADDR_W'(BOUNDARY - 1));
        to_span   = CW'(SPAN) - off_w;

        n_calc = r_reg;
        if (to_bound < n_calc) begin
            n_calc = to_bound;
        end
        if (to_span < n_calc) begin
            n_calc = to_span;
        end

        // end_off is the byte offset just past the burst, measured from the
        // aligned base address.
        end_off   = off_w + n_calc;
        beats     = (end_off + CW'(BPB - 1)) >> OFF_W;
        len_calc  = 8'(beats - CW'(1));
        last_off  = OFF_W'(end_off - CW'(1));
        base_addr = {a_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end

    // A single-beat burst has its first and last beat in the same word.
    // In that case the last-beat strobe must equal the first-beat strobe.
    for (genvar gi = 0; gi < BPB; gi++) begin : g_strb
        localparam logic [CW-1:0]    IDX_W = CW'(gi);
        localparam logic [OFF_W-1:0] IDX_O = OFF_W'(gi);
        assign first_strb[gi] = (IDX_W >= off_w) && (IDX_W < end_off);
        assign last_strb[gi]  = (len_calc == 8'd0) ? first_strb[gi] : (IDX_O <= last_off);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            r_reg          <= '0;
            n_reg          <= '0;
            abort_reg      <= 1'b0;
            valid_reg      <= 1'b0;
            addr_reg       <= '0;
            len_reg        <= '0;
            first_strb_reg <= '0;
            last_strb_reg  <= '0;
            last_reg       <= 1'b0;
            done_reg       <= 1'b0;
            aborted_reg    <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        a_reg     <= addr_i;
                        r_reg     <= CW'(bytes_i);
                        abort_reg <= 1'b0;
                        if (bytes_i == '0) begin
                            state_reg <= FIN;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (abort_i) begin
                        state_reg   <= FIN;
                        done_reg    <= 1'b1;
                        aborted_reg <= 1'b1;
                    end else begin
                        n_reg          <= n_calc;
                        addr_reg       <= base_addr;
                        len_reg        <= len_calc;
                        first_strb_reg <= first_strb;
                        last_strb_reg  <= last_strb;
                        last_reg       <= (n_calc == r_reg);
                        valid_reg      <= 1'b1;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The offered request is never withdrawn.
                    // An abort only prevents the next burst from being planned.
                    if (abort_i) begin
                        abort_reg <= 1'b1;
                    end
                    if (req_ready_i) begin
                        valid_reg <= 1'b0;
                        a_reg     <= a_reg + ADDR_W'(n_reg);
                        r_reg     <= r_reg - n_reg;
                        if (last_reg || abort_reg || abort_i) begin
                            state_reg   <= FIN;
                            done_reg    <= 1'b1;
                            aborted_reg <= abort_reg || abort_i;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end
                FIN: begin
                    // done/aborted were registered on entry to FIN.
                    // They are cleared here by the default assignments above.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_valid_o      = valid_reg;
    assign req_addr_o       = addr_reg;
    assign req_len_o        = len_reg;
    assign req_first_strb_o = first_strb_reg;
    assign req_last_strb_o  = last_strb_reg;
    assign req_last_o       = last_reg;
    assign busy_o           = (state_reg != IDLE);
    assign done_o           = done_reg;
    assign aborted_o        = aborted_reg;

endmodule

// File: tb/tb_dma_burst_planner.sv
// Testbench for dma_burst_planner with the default parameters.
// A behavioural model plans each job into a queue of expected bursts.
// Model widths: 4096-byte boundary, 256 beats of 64 bytes.
// The DUT's offered requests are compared against the head of that queue.
module tb_dma_burst_planner;

    localparam int DATA_W    = 512;
    localparam int MAX_BEATS = 256;
    localparam int BOUNDARY  = 4096;
    localparam int ADDR_W    = 32;
    localparam int LEN_W     = 32;
    localparam int BPB       = DATA_W / 8;

    logic              clk;
    logic              rstn;
    logic              start_i;
    logic [ADDR_W-1:0] addr_i;
    logic [LEN_W-1:0]  bytes_i;
    logic              abort_i;
    logic              req_valid_o;
    logic              req_ready_i;
    logic [ADDR_W-1:0] req_addr_o;
    logic [7:0]        req_len_o;
    logic [BPB-1:0]    req_first_strb_o;
    logic [BPB-1:0]    req_last_strb_o;
    logic              req_last_o;
    logic              busy_o;
    logic              done_o;
    logic              aborted_o;

    dma_burst_planner #(
        .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .BOUNDARY(BOUNDARY),
        .ADDR_W(ADDR_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .start_i(start_i), .addr_i(addr_i), .bytes_i(bytes_i),
        .abort_i(abort_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_addr_o(req_addr_o), .req_len_o(req_len_o),
        .req_first_strb_o(req_first_strb_o), .req_last_strb_o(req_last_strb_o),
        .req_last_o(req_last_o),
        .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [63:0] fs;
        logic [63:0] ls;
        logic        last;
    } burst_t;

    burst_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference planner: walks the job in plain integer arithmetic.
    task automatic plan_job(input logic [31:0] addr, input logic [31:0] nbytes);
        longint a, r, off, tb, lim, n, endb;
        burst_t b;
        a = addr;
        r = nbytes;
        exp_q.delete();
        while (r > 0) begin
            off  = a % BPB;
            tb   = BOUNDARY - (a % BOUNDARY);
            lim  = MAX_BEATS * BPB - off;
            n    = r;
            if (tb < n)  n = tb;
            if (lim < n) n = lim;
            endb = off + n;
            b.addr = 32'(a - off);
            b.len  = 8'((endb + BPB - 1) / BPB - 1);
            for (int k = 0; k < BPB; k++) begin
                b.fs[k] = (k >= off) && (k < endb);
                b.ls[k] = (k <= (endb - 1) % BPB);
            end
            if (b.len == 8'd0) b.ls = b.fs;
            b.last = (r - n == 0);
            exp_q.push_back(b);
            a = (a + n) % 64'h1_0000_0000;
            r = r - n;
        end
    endtask

    task automatic check_fields(input string tag, input burst_t b);
        check({tag, "_addr"}, req_addr_o, b.addr);
        check({tag, "_len"},  req_len_o, b.len);
        check({tag, "_fstrb"}, req_first_strb_o, b.fs);
        check({tag, "_lstrb"}, req_last_strb_o, b.ls);
        check({tag, "_last"}, req_last_o, b.last);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, req_valid_o, 0);
        check({tag, "_addr"}, req_addr_o, 0);
        check({tag, "_len"}, req_len_o, 0);
        check({tag, "_fstrb"}, req_first_strb_o, 0);
        check({tag, "_lstrb"}, req_last_strb_o, 0);
        check({tag, "_last"}, req_last_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_aborted"}, aborted_o, 0);
    endtask

    // Called at a negedge; returns once req_valid_o is seen (bounded).
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (req_valid_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("wait_valid_timeout", 0, 1);
    endtask

    task automatic start_job(input logic [31:0] addr, input logic [31:0] nbytes);
        @(negedge clk);
        start_i = 1'b1; addr_i = addr; bytes_i = nbytes; req_ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Full job with random back-pressure.
    // Spurious start_i pulses are injected while busy.
    task automatic run_job(input logic [31:0] addr, input logic [31:0] nbytes, input int ready_pct);
        int cyc, exp_valid_at, exp_done_at, nb;
        bit new_burst, finished;
        burst_t b;
        plan_job(addr, nbytes);
        nb = exp_q.size();
        $display("job addr=%h bytes=%0d bursts=%0d ready=%0d%%", addr, nbytes, nb, ready_pct);
        start_job(addr, nbytes);
        cyc = 1;
        exp_valid_at = 2;
        exp_done_at = (nb == 0) ? 1 : -1;
        new_burst = 1'b1;
        finished = 1'b0;
        while (!finished && cyc < 1000) begin
            check("busy", busy_o, 1);
            if (done_o) begin
                check("done_cycle", cyc, exp_done_at);
                check("aborted", aborted_o, 0);
                check("bursts_left", exp_q.size(), 0);
                check("valid_at_done", req_valid_o, 0);
                finished = 1'b1;
                start_i = 1'b0;
                req_ready_i = 1'b0;
            end else begin
                if (req_valid_o) begin
                    if (exp_q.size() == 0) begin
                        check("extra_valid", 1, 0);
                        req_ready_i = 1'b0;
                    end else begin
                        b = exp_q[0];
                        if (new_burst) begin
                            check("valid_latency", cyc, exp_valid_at);
                            new_burst = 1'b0;
                        end
                        check_fields("req", b);
                        req_ready_i = ($urandom_range(0, 99) < ready_pct);
                        if (req_ready_i) begin
                            $display("  burst addr=%h len=%0d last=%0b cyc=%0d", b.addr, b.len, b.last, cyc);
                            void'(exp_q.pop_front());
                            new_burst = 1'b1;
                            if (exp_q.size() == 0) exp_done_at = cyc + 1;
                            else exp_valid_at = cyc + 2;
                        end
                    end
                end else begin
                    if (!new_burst) check("valid_dropped", 0, 1);
                    req_ready_i = 1'($urandom_range(0, 1));
                end
                start_i = ($urandom_range(0, 3) == 0);
                addr_i  = $urandom;
                bytes_i = $urandom_range(0, 500);
                @(negedge clk);
                cyc++;
            end
        end
        if (!finished) check("job_timeout", 0, 1);
        start_i = 1'b0;
        req_ready_i = 1'b0;
        @(negedge clk);
        check("idle_after_done", busy_o, 0);
    endtask

    initial begin
        bit ok;
        burst_t b;
        logic [31:0] ra, rb;

        rstn = 1'b0; start_i = 1'b0; addr_i = '0; bytes_i = '0;
        abort_i = 1'b0; req_ready_i = 1'b0;
        #3;
        check_all_zero("rst");
        repeat (3) @(negedge clk);
        check_all_zero("rst_hold");
        rstn = 1'b1;
        @(negedge clk);

        // Directed jobs
        run_job(32'h0000_1000, 16384, 100);
        run_job(32'h0000_0FF0, 40, 100);
        run_job(32'h0000_0010, 100, 100);
        run_job(32'h0000_0000, 0, 100);
        run_job(32'h0000_0FFF, 1, 60);
        run_job(32'h0000_0801, 20000, 70);
        run_job(32'hFFFF_FFC0, 256, 100);

        // Randomized jobs
        for (int j = 0; j < 40; j++) begin
            case ($urandom_range(0, 3))
                0: ra = $urandom;
                1: ra = ($urandom & 32'hFFFF_F000) - $urandom_range(1, 64);
                2: ra = $urandom_range(0, 8191);
                default: ra = 32'hFFFF_FF00 + $urandom_range(0, 255);
            endcase
            case ($urandom_range(0, 3))
                0: rb = $urandom_range(1, 64);
                1: rb = $urandom_range(1, 5000);
                2: rb = $urandom_range(10000, 40000);
                default: rb = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 200);
            endcase
            run_job(ra, rb, $urandom_range(30, 100));
        end

        // Stall for 5 cycles with an abort pulse inside the window.
        // Expect exactly one handshake, then an aborted done.
        $display("job abort_during_stall addr=00000000 bytes=16384");
        plan_job(32'h0, 16384);
        b = exp_q[0];
        start_job(32'h0, 16384);
        wait_valid(ok);
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", req_valid_o, 1);
            check_fields("stall", b);
            req_ready_i = 1'b0;
            abort_i = (k == 2);
            @(negedge clk);
        end
        abort_i = 1'b0;
        check("stall_end_valid", req_valid_o, 1);
        check_fields("stall_end", b);
        req_ready_i = 1'b1;
        @(negedge clk);
        req_ready_i = 1'b0;
        check("abort_done", done_o, 1);
        check("abort_flag", aborted_o, 1);
        check("abort_no_valid", req_valid_o, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_quiet_valid", req_valid_o, 0);
            check("abort_quiet_busy", busy_o, 0);
        end

        // Abort arriving in the planning cycle after a handshake.
        $display("job abort_in_calc addr=00000000 bytes=16384");
        start_job(32'h0, 16384);
        wait_valid(ok);
        req_ready_i = 1'b1;
        @(negedge clk);
        req_ready_i = 1'b0;
        check("calc_gap_valid", req_valid_o, 0);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("calc_abort_done", done_o, 1);
        check("calc_abort_flag", aborted_o, 1);
        check("calc_abort_valid", req_valid_o, 0);
        @(negedge clk);
        check("calc_abort_idle", busy_o, 0);

        // Reset asserted while a burst is offered, then a clean restart.
        $display("job reset_mid_burst addr=00001000 bytes=16384");
        start_job(32'h1000, 16384);
        wait_valid(ok);
        #2 rstn = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_done", done_o, 0);
            check("post_rst_busy", busy_o, 0);
        end
        run_job(32'h0000_0040, 64, 100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
